// File: rtl/cordic_pkg.sv
// ============================================================================
// Module      : cordic_pkg
// Description : Shared types and control-word bit indices for the CORDIC
//               sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cordic_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ITER = 3'd1,
      ST_WR_X = 3'd2,
      ST_WR_Y = 3'd3,
      ST_HOLD = 3'd4
   } cordic_ctrl_state_t;

   // Bit positions inside the core control word c[8:1]; c[3], c[4] are reserved
   localparam int C_LOAD_SEL = 1;
   localparam int C_LR_EN    = 2;
   localparam int C_MID_SEL  = 5;
   localparam int C_X_EN     = 6;
   localparam int C_Y_EN     = 7;
   localparam int C_ANG_EN   = 8;

endpackage

`default_nettype wire

// File: rtl/cordic_ctrl_if.sv
// ============================================================================
// Module      : cordic_ctrl_if
// Description : Handshake and core-control bundle of the CORDIC controller.
//               CORDIC_CTRL_ABORT_EN adds the abort input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cordic_ctrl_if #(
   parameter int N = 7
);

   logic                 in_valid;
   logic                 in_ready;
   logic                 out_valid;
   logic                 out_ready;
   logic                 busy;
   logic [8:1]           c;
   logic [$clog2(N)-1:0] cnt;
`ifdef CORDIC_CTRL_ABORT_EN
   logic                 abort;

   modport master (
      input  in_valid, out_ready, abort,
      output in_ready, out_valid, busy, c, cnt
   );

   modport slave (
      output in_valid, out_ready, abort,
      input  in_ready, out_valid, busy, c, cnt
   );
`else
   modport master (
      input  in_valid, out_ready,
      output in_ready, out_valid, busy, c, cnt
   );

   modport slave (
      output in_valid, out_ready,
      input  in_ready, out_valid, busy, c, cnt
   );
`endif

endinterface

`default_nettype wire

// File: rtl/cordic_ctrl.sv
// ============================================================================
// Module      : cordic_ctrl
// Description : Sequencer for the iterative CORDIC core: load, N iterations,
//               X/Y capture, then hold the result until it is accepted.
//               CORDIC_CTRL_ABORT_EN enables the synchronous abort input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_ctrl
   import cordic_pkg::*;
#(
   parameter int N = 7
) (
   input  logic          clk,
   input  logic          rst,
   cordic_ctrl_if.master bus
);

   localparam int                CNT_W      = $clog2(N);
   localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(N - 1);
   localparam logic [CNT_W-1:0]  C_CNT_PEN  = CNT_W'(N - 2);
   localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);

   cordic_ctrl_state_t r_state;
   cordic_ctrl_state_t w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               w_abort;

`ifdef CORDIC_CTRL_ABORT_EN
   assign w_abort = bus.abort;
`else
   assign w_abort = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // State and iteration-index registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and next-count decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (bus.in_valid && !w_abort) begin
               w_state_nxt = ST_ITER;
               w_cnt_nxt   = '0;
            end
         end
         ST_ITER: begin
            // The last shift amount N-1 is consumed by the WR_X/WR_Y pair
            if (r_cnt == C_CNT_PEN) begin
               w_state_nxt = ST_WR_X;
               w_cnt_nxt   = C_CNT_LAST;
            end else begin
               w_cnt_nxt   = r_cnt + C_CNT_ONE;
            end
         end
         ST_WR_X: begin
            w_state_nxt = ST_WR_Y;
            w_cnt_nxt   = C_CNT_LAST;
         end
         ST_WR_Y: begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = C_CNT_LAST;
         end
         ST_HOLD: begin
            if (bus.out_ready) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase

      if (w_abort && (r_state != ST_IDLE)) begin
         w_state_nxt = ST_IDLE;
         w_cnt_nxt   = '0;
      end
   end

   // ------------------------------------------------------------------------
   // Output decode; everything is forced quiet while reset is asserted
   // ------------------------------------------------------------------------
   always_comb begin
      bus.c         = '0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b0;
      if (rst) begin
         bus.busy = (r_state != ST_IDLE);
         case (r_state)
            ST_IDLE: begin
               bus.in_ready = 1'b1;
               if (bus.in_valid && !w_abort) begin
                  bus.c[C_LOAD_SEL] = 1'b1;
                  bus.c[C_LR_EN]    = 1'b1;
                  bus.c[C_ANG_EN]   = 1'b1;
               end
            end
            ST_ITER: begin
               bus.c[C_LR_EN] = !w_abort;
            end
            ST_WR_X: begin
               bus.c[C_X_EN] = !w_abort;
            end
            ST_WR_Y: begin
               bus.c[C_MID_SEL] = !w_abort;
               bus.c[C_Y_EN]    = !w_abort;
            end
            ST_HOLD: begin
               bus.out_valid = !w_abort;
            end
            default: begin
               bus.c = '0;
            end
         endcase
      end
   end

   assign bus.cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cordic_ctrl.sv
// ============================================================================
// Module      : tb_cordic_ctrl
// Description : Scoreboard bench for cordic_ctrl (N=7 and N=2 instances).
//               CORDIC_CTRL_ABORT_EN also exercises the abort input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cordic_ctrl;

   localparam int N = 7;

   typedef struct {
      logic [8:1] c;
      int         cnt;
      bit         ov;
      bit         ir;
      bit         bz;
   } exp_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   exp_t sb[$];

   cordic_ctrl_if #(.N(N)) bus ();
   cordic_ctrl_if #(.N(2)) bus2 ();

   cordic_ctrl #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   cordic_ctrl #(.N(2)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [8:1] c, input int cnt, input bit ov, input bit ir, input bit bz);
      exp_t e;
      e.c = c; e.cnt = cnt; e.ov = ov; e.ir = ir; e.bz = bz;
      sb.push_back(e);
   endtask

   // Trace of one operation after the accept cycle: N-1 iterations, WR_X, WR_Y
   task automatic push_op();
      for (int i = 0; i < N - 1; i++) push(8'h02, i, 1'b0, 1'b0, 1'b1);
      push(8'h20, N - 1, 1'b0, 1'b0, 1'b1);
      push(8'h50, N - 1, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic push_hold(input int k);
      for (int i = 0; i < k; i++) push(8'h00, N - 1, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic cmp_head(input string tag, output bit ov);
      exp_t e;
      e = sb.pop_front();
      check({tag, ".c"},         32'(bus.c),         32'(e.c));
      check({tag, ".cnt"},       32'(bus.cnt),       e.cnt);
      check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(e.ov));
      check({tag, ".in_ready"},  32'(bus.in_ready),  32'(e.ir));
      check({tag, ".busy"},      32'(bus.busy),      32'(e.bz));
      ov = e.ov;
   endtask

   // Compares queued entries on consecutive cycles; first_ov is the index
   // (cycles after the accept) of the first entry expecting out_valid.
   task automatic drain(input string tag, output int first_ov);
      int idx;
      bit ov;
      idx      = 0;
      first_ov = -1;
      while (sb.size() > 0) begin
         if (idx > 0) begin
            @(posedge clk);
            #2;
         end
         idx++;
         cmp_head(tag, ov);
         if (ov && first_ov < 0) first_ov = idx;
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".in_ready"},  32'(bus.in_ready),  32'd1);
      check({tag, ".busy"},      32'(bus.busy),      32'd0);
      check({tag, ".cnt"},       32'(bus.cnt),       32'd0);
      check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      int lat;
      int acc_t[$];
      n_checks = 0;
      n_errors = 0;
      rst           = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus2.in_valid  = 1'b0;
      bus2.out_ready = 1'b1;
`ifdef CORDIC_CTRL_ABORT_EN
      bus.abort  = 1'b0;
      bus2.abort = 1'b0;
`endif

      // Reset state, with a pending in_valid that must not produce a load
      repeat (2) @(posedge clk);
      #2;
      bus.in_valid = 1'b1;
      #1;
      check("rst.c",         32'(bus.c),         32'd0);
      check("rst.cnt",       32'(bus.cnt),       32'd0);
      check("rst.in_ready",  32'(bus.in_ready),  32'd0);
      check("rst.out_valid", 32'(bus.out_valid), 32'd0);
      check("rst.busy",      32'(bus.busy),      32'd0);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("post_rst.in_ready", 32'(bus.in_ready), 32'd1);
      check("post_rst.c",        32'(bus.c),        32'd0);

      // Single operation, result held back for several cycles
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      #1;
      check("op1.load_c", 32'(bus.c),   32'h83);
      check("op1.load_cnt", 32'(bus.cnt), 32'd0);
      push_op();
      push_hold(6);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      #1;
      drain("op1", lat);
      check("op1.latency", 32'(lat), N + 2);
      bus.out_ready = 1'b1;
      #1;
      check("op1.hold_ov", 32'(bus.out_valid), 32'd1);
      check("op1.hold_ir", 32'(bus.in_ready),  32'd0);
      @(posedge clk);
      #2;
      check_idle("op1.back_idle");

      // Back-to-back: in_valid held high, out_ready tied high
      for (int t = 0; t <= 40; t++) begin
         bit ov;
         if (t > 0) begin
            @(posedge clk);
            #1;
         end
         bus.in_valid = (t <= 30);
         #1;
         if (sb.size() > 0) begin
            cmp_head("b2b", ov);
         end else if (bus.in_valid) begin
            check("b2b.in_ready", 32'(bus.in_ready), 32'd1);
            check("b2b.load_c",   32'(bus.c),        32'h83);
            if (bus.in_ready) begin
               acc_t.push_back(t);
               push_op();
               push_hold(1);
            end
         end else begin
            check_idle("b2b.idle");
         end
      end
      bus.in_valid = 1'b0;
      check("b2b.accepts", 32'(acc_t.size()), 32'd4);
      for (int i = 1; i < acc_t.size(); i++)
         check("b2b.period", 32'(acc_t[i] - acc_t[i-1]), N + 3);
      sb.delete();

      // Asynchronous reset in the middle of the iteration phase
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      #1;
      check("mid.load_c", 32'(bus.c), 32'h83);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      #1;
      repeat (3) begin
         @(posedge clk);
         #2;
      end
      check("mid.cnt3", 32'(bus.cnt), 32'd3);
      rst = 1'b0;
      #1;
      check("mid.c",         32'(bus.c),         32'd0);
      check("mid.cnt",       32'(bus.cnt),       32'd0);
      check("mid.out_valid", 32'(bus.out_valid), 32'd0);
      check("mid.in_ready",  32'(bus.in_ready),  32'd0);
      check("mid.busy",      32'(bus.busy),      32'd0);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #2;
      check_idle("mid.idle");
      bus.in_valid = 1'b1;
      #1;
      check("op2.load_c", 32'(bus.c), 32'h83);
      push_op();
      push_hold(1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      #1;
      drain("op2", lat);
      check("op2.latency", 32'(lat), N + 2);
      @(posedge clk);
      #2;
      check_idle("op2.back_idle");

`ifdef CORDIC_CTRL_ABORT_EN
      // Abort during WR_X suppresses the X write and returns to IDLE
      bus.in_valid = 1'b1;
      #1;
      for (int i = 0; i < N - 1; i++) push(8'h02, i, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      #1;
      drain("ab", lat);
      @(posedge clk);
      #1;
      bus.abort = 1'b1;
      #1;
      check("ab.wrx_c", 32'(bus.c), 32'd0);
      @(posedge clk);
      #1;
      bus.abort = 1'b0;
      #1;
      check_idle("ab.idle");
      repeat (3) begin
         @(posedge clk);
         #2;
         check("ab.no_ov", 32'(bus.out_valid), 32'd0);
      end
      // Abort in IDLE outranks in_valid
      bus.abort    = 1'b1;
      bus.in_valid = 1'b1;
      #1;
      check("ab.idle_c", 32'(bus.c), 32'd0);
      @(posedge clk);
      #1;
      bus.abort    = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      check("ab.no_load", 32'(bus.busy), 32'd0);
`endif

      // N=2 instance: cnt 0,1,1 and out_valid four cycles after the accept
      bus2.in_valid = 1'b1;
      #1;
      check("n2.load_c", 32'(bus2.c), 32'h83);
      @(posedge clk);
      #1;
      bus2.in_valid = 1'b0;
      #1;
      check("n2.iter_c",   32'(bus2.c),   32'h02);
      check("n2.iter_cnt", 32'(bus2.cnt), 32'd0);
      @(posedge clk);
      #2;
      check("n2.wrx_c",   32'(bus2.c),   32'h20);
      check("n2.wrx_cnt", 32'(bus2.cnt), 32'd1);
      @(posedge clk);
      #2;
      check("n2.wry_c",   32'(bus2.c),   32'h50);
      check("n2.wry_cnt", 32'(bus2.cnt), 32'd1);
      check("n2.wry_ov",  32'(bus2.out_valid), 32'd0);
      @(posedge clk);
      #2;
      check("n2.hold_ov", 32'(bus2.out_valid), 32'd1);
      check("n2.hold_c",  32'(bus2.c),         32'd0);
      @(posedge clk);
      #2;
      check("n2.idle_ir", 32'(bus2.in_ready), 32'd1);
      check("n2.idle_ov", 32'(bus2.out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
